uart_rx_frame_ctrl: RTL

- Sequences the uart_rx core: owns its byte handshake (data_valid level in, one-cycle ready pulse out) and assembles received bytes into framed packets.
- Frame format: SYNC_BYTE, LEN, LEN payload bytes, XOR checksum.
- Validated payloads are held in an internal buffer for a downstream consumer, which reads them by address and releases them with an ack.
- Sits between uart_rx and application logic in board tops, replacing ad-hoc per-top handshake code.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_frame_buf.sv | 25 ++
 rtl/uart_rx_frame_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive framing logic: FSM state
// encodings and default parameter values for simulation and board builds.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CSUM    = 3'd3,
    ST_HOLD    = 3'd4
  } frame_state_t;

  localparam logic [7:0] SYNC_BYTE_DEF   = 8'h55;
  localparam int         BAUD_MULT_SIM   = 3;
  localparam int         BAUD_MULT_BOARD = 1666;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload store for one framed packet: single synchronous write port,
// asynchronous read port for the downstream consumer.
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [DEPTH];

  // NOTE: storage is deliberately not reset; its contents are only
  // meaningful after a frame writes them, and a reset would cost a mux per bit.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Consumes bytes from uart_rx with a valid/ready-pulse handshake and
// assembles SYNC, LEN, payload, XOR-checksum frames into a held packet.
module uart_rx_frame_ctrl
  import uart_pkg::*;
#(
  parameter int         BAUD_MULT    = BAUD_MULT_BOARD,
  parameter int         MAX_LEN      = 16,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_BITS = 40,
  localparam int        AW           = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [7:0]    i_rx_byte,
  input  logic          i_rx_valid,
  output logic          o_rx_ready,
  output logic          o_pkt_valid,
  output logic [7:0]    o_pkt_len,
  input  logic [AW-1:0] i_rd_addr,
  output logic [7:0]    o_rd_data,
  input  logic          i_pkt_ack,
  output logic          o_err_csum,
  output logic          o_err_len,
  output logic          o_err_timeout,
  output logic          o_busy
);

  localparam int         TO_LIMIT  = TIMEOUT_BITS * BAUD_MULT;
  localparam int         TO_W      = $clog2(TO_LIMIT + 1);
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  frame_state_t    r_state, w_state_nxt;
  logic            r_rx_ready;
  logic [7:0]      r_len, r_csum, r_pkt_len;
  logic [AW-1:0]   r_idx;
  logic [TO_W-1:0] r_to_cnt;
  logic            r_pkt_valid, r_err_csum, r_err_len, r_err_to;

  logic w_consume, w_active, w_to_hit;
  logic w_len_load, w_buf_we, w_pkt_set, w_pkt_clr;
  logic w_err_csum, w_err_len, w_err_to;

  // The ready pulse itself blocks a second consume of the same held byte.
  assign w_consume = i_rx_valid && !r_rx_ready && (r_state != ST_HOLD);
  assign w_active  = (r_state == ST_LEN) || (r_state == ST_PAYLOAD) || (r_state == ST_CSUM);
  assign w_to_hit  = w_active && (r_to_cnt == TO_W'(TO_LIMIT - 1));

  // NOTE: every output of this block gets a default first, so no path
  // through the case statement can leave a signal unassigned (no latches).
  always_comb begin
    w_state_nxt = r_state;
    w_len_load  = 1'b0;
    w_buf_we    = 1'b0;
    w_pkt_set   = 1'b0;
    w_pkt_clr   = 1'b0;
    w_err_csum  = 1'b0;
    w_err_len   = 1'b0;
    w_err_to    = 1'b0;
    unique case (r_state)
      ST_HUNT: begin
        if (w_consume && (i_rx_byte == SYNC_BYTE)) w_state_nxt = ST_LEN;
      end
      ST_LEN: begin
        if (w_consume) begin
          w_len_load = 1'b1;
          if (i_rx_byte > MAX_LEN_B) begin
            w_err_len   = 1'b1;
            w_state_nxt = ST_HUNT;
          end else if (i_rx_byte == 8'd0) begin
            w_state_nxt = ST_CSUM;
          end else begin
            w_state_nxt = ST_PAYLOAD;
          end
        end else if (w_to_hit) begin
          w_err_to    = 1'b1;
          w_state_nxt = ST_HUNT;
        end
      end
      ST_PAYLOAD: begin
        if (w_consume) begin
          w_buf_we = 1'b1;
          if (8'(r_idx) == (r_len - 8'd1)) w_state_nxt = ST_CSUM;
        end else if (w_to_hit) begin
          w_err_to    = 1'b1;
          w_state_nxt = ST_HUNT;
        end
      end
      ST_CSUM: begin
        if (w_consume) begin
          if (i_rx_byte == r_csum) begin
            w_pkt_set   = 1'b1;
            w_state_nxt = ST_HOLD;
          end else begin
            w_err_csum  = 1'b1;
            w_state_nxt = ST_HUNT;
          end
        end else if (w_to_hit) begin
          w_err_to    = 1'b1;
          w_state_nxt = ST_HUNT;
        end
      end
      ST_HOLD: begin
        if (i_pkt_ack) begin
          w_pkt_clr   = 1'b1;
          w_state_nxt = ST_HUNT;
        end
      end
      default: w_state_nxt = ST_HUNT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_ready  <= 1'b0;
      r_len       <= '0;
      r_csum      <= '0;
      r_idx       <= '0;
      r_to_cnt    <= '0;
      r_pkt_valid <= 1'b0;
      r_pkt_len   <= '0;
      r_err_csum  <= 1'b0;
      r_err_len   <= 1'b0;
      r_err_to    <= 1'b0;
    end else begin
      r_rx_ready <= w_consume;
      r_err_csum <= w_err_csum;
      r_err_len  <= w_err_len;
      r_err_to   <= w_err_to;

      if (w_len_load) begin
        r_len  <= i_rx_byte;
        r_csum <= i_rx_byte;
        r_idx  <= '0;
      end else if (w_buf_we) begin
        r_csum <= r_csum ^ i_rx_byte;
        r_idx  <= r_idx + 1'b1;
      end

      if (w_pkt_set) begin
        r_pkt_valid <= 1'b1;
        r_pkt_len   <= r_len;
      end else if (w_pkt_clr) begin
        r_pkt_valid <= 1'b0;
      end

      // Timer runs only while a frame is open and restarts on every byte.
      if (w_consume || !w_active) begin
        r_to_cnt <= '0;
      end else if (r_to_cnt != TO_W'(TO_LIMIT)) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
    end
  end

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .i_clk   (i_clk),
    .i_we    (w_buf_we),
    .i_waddr (r_idx),
    .i_wdata (i_rx_byte),
    .i_raddr (i_rd_addr),
    .o_rdata (o_rd_data)
  );

  assign o_rx_ready    = r_rx_ready;
  assign o_pkt_valid   = r_pkt_valid;
  assign o_pkt_len     = r_pkt_len;
  assign o_err_csum    = r_err_csum;
  assign o_err_len     = r_err_len;
  assign o_err_timeout = r_err_to;
  assign o_busy        = (r_state != ST_HUNT);

endmodule
